// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver (LSB first, idle high) feeding a small FIFO
// that is drained through a valid/ready handshake.
//
// Ports:
//   clock_i      system clock, all logic on the rising edge
//   reset_i      synchronous, active-high reset
//   uart_rx_i    asynchronous serial input pin
//   rx_data_o    registered FIFO head byte, meaningful while rx_valid_o = 1
//   rx_valid_o   registered FIFO-not-empty
//   rx_ready_i   consumer takes the head byte when rx_valid_o & rx_ready_i
//   frame_err_o  1-cycle pulse: stop bit sampled low
//   overrun_o    1-cycle pulse: received byte dropped, FIFO was full
//   busy_o       receiver FSM is not in IDLE
module uart_rx_fifo #(
    parameter int unsigned CLK_HZ = 10_000_000,
    parameter int unsigned BAUD   = 115_200,
    parameter int unsigned DEPTH  = 4
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       uart_rx_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
);

    localparam int unsigned DIV = CLK_HZ / BAUD;
    localparam int unsigned CW  = $clog2(DIV);
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned PW  = AW + 1;

    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_e;

    // ------------------------------------------------------------------
    // Input synchronizer
    // ------------------------------------------------------------------
    logic       sync1_q;
    logic       rx_s_q;
    // The synchronizer resets to idle-high, so for two cycles after reset its
    // output does not reflect the pin. BREAK only trusts rx_s once two real
    // samples have passed, otherwise a line held low through reset would be
    // mistaken for an idle line and start a bogus frame.
    logic [1:0] prime_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            prime_q <= '0;
        end else begin
            sync1_q <= uart_rx_i;
            rx_s_q  <= sync1_q;
            prime_q <= {prime_q[0], 1'b1};
        end
    end

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bitn_q, bitn_d;
    logic [7:0]    shift_q, shift_d;
    logic          push_req;
    logic          frame_err_d;
    logic          cnt_zero;

    assign cnt_zero = (cnt_q == '0);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= S_BREAK;
            cnt_q   <= '0;
            bitn_q  <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bitn_q  <= bitn_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bitn_d      = bitn_q;
        shift_d     = shift_q;
        push_req    = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    cnt_d   = HALF_M1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_zero) begin
                    if (!rx_s_q) begin
                        cnt_d   = FULL_M1;
                        bitn_d  = '0;
                        state_d = S_DATA;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_zero) begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    cnt_d   = FULL_M1;
                    if (bitn_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bitn_d = bitn_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_STOP: begin
                if (cnt_zero) begin
                    if (rx_s_q) begin
                        push_req = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_BREAK: begin
                if (prime_q[1] && rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_BREAK;
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic          rx_valid_q, rx_valid_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          frame_err_q;
    logic          overrun_q, overrun_d;
    logic          full;
    logic          pop;
    logic          do_push;

    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop     = rx_valid_q & rx_ready_i;
    // A pop in the same cycle frees a slot before the push is considered.
    assign do_push = push_req && (!full || pop);

    always_comb begin
        overrun_d  = push_req && full && !pop;
        rptr_d     = rptr_q + PW'(pop);
        wptr_d     = wptr_q + PW'(do_push);
        rx_valid_d = (wptr_d != rptr_d);
        rx_data_d  = rx_data_q;
        // The head register is loaded from the post-update FIFO; when the new
        // byte lands in the head slot it is forwarded past the memory.
        if (rx_valid_d) begin
            if (do_push && (wptr_q[AW-1:0] == rptr_d[AW-1:0])) begin
                rx_data_d = shift_q;
            end else begin
                rx_data_d = mem_q[rptr_d[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i && do_push) begin
            mem_q[wptr_q[AW-1:0]] <= shift_q;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rptr_q      <= '0;
            wptr_q      <= '0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rptr_q      <= rptr_d;
            wptr_q      <= wptr_d;
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data_o   = rx_data_q;
    assign rx_valid_o  = rx_valid_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
    assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: self-checking bench for uart_rx_fifo at DIV = 16.
// A queue-based model tracks the FIFO contents and expected flag pulses;
// serial frames are driven bit by bit from a table, by hand and at random.
module tb_uart_rx_fifo;

    localparam int DIV       = 16;
    localparam int DEPTH     = 4;
    // Clock edge (counted from the edge before the start bit is driven) on
    // which the stop bit is sampled: 2 sync flops + IDLE + half bit + 9 bits.
    localparam int STOP_EDGE = 3 + DIV / 2 + 9 * DIV;

    localparam int M_HOLD0 = 0;
    localparam int M_HOLD1 = 1;
    localparam int M_PULSE = 2;
    localparam int M_RAND  = 3;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       uart_rx  = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_rx_fifo #(
        .CLK_HZ(1_600_000),
        .BAUD  (100_000),
        .DEPTH (DEPTH)
    ) dut (
        .clock_i    (clk),
        .reset_i    (reset),
        .uart_rx_i  (uart_rx),
        .rx_data_o  (rx_data),
        .rx_valid_o (rx_valid),
        .rx_ready_i (rx_ready),
        .frame_err_o(frame_err),
        .overrun_o  (overrun),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    int         checks  = 0;
    int         errors  = 0;
    int         ferr_cnt = 0;
    int         ovr_cnt  = 0;
    logic [7:0] model_q[$];
    logic [7:0] got_q[$];
    bit         evt_pending = 1'b0;
    bit         evt_stop    = 1'b0;
    logic [7:0] evt_data    = '0;

    typedef struct {
        logic [7:0] data;
        bit         stop;
        int         mode;
        bit         drain;
        int         exp_ferr;
        int         exp_ovr;
    } vec_t;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Per-cycle comparison against the model, sampled at the falling edge.
    // A stop-sample event is applied first (pops for the same edge were
    // already taken at the previous falling edge), then outputs are compared,
    // then a handshake seen now is recorded as a pop on the coming edge.
    task automatic monitor();
        bit exp_f;
        bit exp_o;
        exp_f = 1'b0;
        exp_o = 1'b0;
        if (reset) begin
            model_q.delete();
            evt_pending = 1'b0;
            return;
        end
        if (evt_pending) begin
            evt_pending = 1'b0;
            if (!evt_stop) exp_f = 1'b1;
            else if (model_q.size() >= DEPTH) exp_o = 1'b1;
            else model_q.push_back(evt_data);
        end
        check("rx_valid", 32'(rx_valid), 32'(model_q.size() != 0));
        if (rx_valid && model_q.size() != 0) check("rx_data", 32'(rx_data), 32'(model_q[0]));
        check("frame_err", 32'(frame_err), 32'(exp_f));
        check("overrun", 32'(overrun), 32'(exp_o));
        if (frame_err) ferr_cnt++;
        if (overrun) ovr_cnt++;
        if (rx_valid && rx_ready) begin
            got_q.push_back(rx_data);
            if (model_q.size() != 0) void'(model_q.pop_front());
        end
    endtask

    // One clock: sample at the falling edge, return just after the rising edge.
    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop, input int mode);
        logic [9:0] fr;
        fr = {stop, d, 1'b0};
        if (mode == M_PULSE) rx_ready = 1'b0;
        for (int i = 0; i < 10 * DIV; i++) begin
            step();
            uart_rx = fr[i / DIV];
            if (mode == M_RAND) rx_ready = 1'($urandom_range(0, 1));
            if (mode == M_PULSE && i == STOP_EDGE - 1) rx_ready = 1'b1;
            if (mode == M_PULSE && i == STOP_EDGE) rx_ready = 1'b0;
            if (i == STOP_EDGE) begin
                evt_pending = 1'b1;
                evt_stop    = stop;
                evt_data    = d;
            end
        end
        uart_rx = 1'b1;
        repeat (6) step();
    endtask

    vec_t       tab [13];
    logic [7:0] exp_got [11];
    int         f0;
    int         o0;
    int         n;
    int         low_cnt;

    initial begin
        tab = '{
            '{8'hA5, 1'b1, M_HOLD1, 1'b0, 0, 0},
            '{8'h3C, 1'b0, M_HOLD1, 1'b0, 1, 0},
            '{8'h11, 1'b1, M_HOLD1, 1'b0, 0, 0},
            '{8'h01, 1'b1, M_HOLD0, 1'b0, 0, 0},
            '{8'h02, 1'b1, M_HOLD0, 1'b0, 0, 0},
            '{8'h03, 1'b1, M_HOLD0, 1'b0, 0, 0},
            '{8'h04, 1'b1, M_HOLD0, 1'b0, 0, 0},
            '{8'h05, 1'b1, M_HOLD0, 1'b1, 0, 1},
            '{8'h21, 1'b1, M_HOLD0, 1'b0, 0, 0},
            '{8'h22, 1'b1, M_HOLD0, 1'b0, 0, 0},
            '{8'h23, 1'b1, M_HOLD0, 1'b0, 0, 0},
            '{8'h24, 1'b1, M_HOLD0, 1'b0, 0, 0},
            '{8'h26, 1'b1, M_PULSE, 1'b1, 0, 0}
        };
        exp_got = '{8'hA5, 8'h11, 8'h01, 8'h02, 8'h03, 8'h04,
                    8'h21, 8'h22, 8'h23, 8'h24, 8'h26};

        // Reset state
        step();
        step();
        check("rst_valid", 32'(rx_valid), 0);
        check("rst_data", 32'(rx_data), 0);
        check("rst_ferr", 32'(frame_err), 0);
        check("rst_ovr", 32'(overrun), 0);
        check("rst_busy", 32'(busy), 1);
        reset = 1'b0;
        repeat (10) step();
        check("idle_busy", 32'(busy), 0);

        // Table: normal byte, framing error + recovery, overrun, full+pop
        for (int r = 0; r < 13; r++) begin
            f0 = ferr_cnt;
            o0 = ovr_cnt;
            if (tab[r].mode == M_HOLD1) rx_ready = 1'b1;
            if (tab[r].mode == M_HOLD0) rx_ready = 1'b0;
            send_frame(tab[r].data, tab[r].stop, tab[r].mode);
            if (tab[r].drain) begin
                rx_ready = 1'b1;
                repeat (8) step();
            end
            check($sformatf("row%0d_ferr_cnt", r), 32'(ferr_cnt - f0), 32'(tab[r].exp_ferr));
            check($sformatf("row%0d_ovr_cnt", r), 32'(ovr_cnt - o0), 32'(tab[r].exp_ovr));
        end
        check("got_count", 32'(got_q.size()), 11);
        for (int k = 0; k < 11 && k < got_q.size(); k++)
            check($sformatf("got%0d", k), 32'(got_q[k]), 32'(exp_got[k]));

        // Short low glitch on the idle line
        f0 = ferr_cnt;
        n  = got_q.size();
        uart_rx = 1'b0;
        repeat (4) step();
        check("glitch_busy", 32'(busy), 1);
        step();
        uart_rx = 1'b1;
        repeat (20) step();
        check("glitch_idle", 32'(busy), 0);
        check("glitch_ferr", 32'(ferr_cnt - f0), 0);
        check("glitch_nobyte", 32'(got_q.size()), 32'(n));

        // Randomized frames with random consumer back-pressure
        for (int r = 0; r < 24; r++) begin
            send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 7) != 0), M_RAND);
        end
        rx_ready = 1'b1;
        repeat (10) step();
        check("rand_drained", 32'(model_q.size()), 0);

        // Reset in the middle of DATA with the line held low
        f0 = ferr_cnt;
        rx_ready = 1'b1;
        uart_rx  = 1'b0;
        repeat (60) step();
        check("mid_busy", 32'(busy), 1);
        reset = 1'b1;
        step();
        step();
        check("mid_rst_valid", 32'(rx_valid), 0);
        check("mid_rst_data", 32'(rx_data), 0);
        check("mid_rst_busy", 32'(busy), 1);
        reset   = 1'b0;
        low_cnt = 0;
        repeat (40) begin
            step();
            if (!busy) low_cnt++;
        end
        check("break_hold", 32'(low_cnt), 0);
        uart_rx = 1'b1;
        n = 0;
        while (busy && n < 20) begin
            step();
            n++;
        end
        check("break_exit", 32'(busy), 0);
        n = got_q.size();
        send_frame(8'h5A, 1'b1, M_HOLD1);
        check("post_rst_count", 32'(got_q.size()), 32'(n + 1));
        if (got_q.size() == n + 1) check("post_rst_data", 32'(got_q[n]), 32'h5A);
        check("post_rst_ferr", 32'(ferr_cnt - f0), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
